// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames a word as start, data (LSB first),
// optional parity and stop bits, driving the field selector of a TX mux.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   tx_data, tx_valid  word to send and its request strobe
//   tx_ready           request can be accepted (FSM idle)
//   parity_en/odd      parity insertion and polarity, latched on accept
//   bit_select         field selector to the TX output mux
//   serial_data        current data bit (1 outside start/data fields)
//   parity_bit         parity of the latched word
//   tx_busy, tx_done   frame in progress / one-cycle completion pulse
module uart_tx_ctrl #(
    parameter int         DATA_WIDTH             = 8,
    parameter int         CLKS_PER_BIT           = 434,
    parameter int         STOP_BITS              = 1,
    parameter logic [1:0] START_BIT_SELECT       = 2'b00,
    parameter logic [1:0] STOP_BIT_SELECT        = 2'b01,
    parameter logic [1:0] SERIAL_DATA_BIT_SELECT = 2'b10,
    parameter logic [1:0] PARITY_BIT_SELECT      = 2'b11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    output logic [1:0]            bit_select,
    output logic                  serial_data,
    output logic                  parity_bit,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_WIDTH - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         r_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_en;
    logic                  r_parity;
    logic [1:0]            r_sel;
    logic                  r_sdata;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_ready;

    state_t                w_state;
    logic [CW-1:0]         w_cnt;
    logic [IW-1:0]         w_idx;
    logic [DATA_WIDTH-1:0] w_shift;
    logic                  w_par_en;
    logic                  w_parity;
    logic [1:0]            w_sel;
    logic                  w_sdata;
    logic                  w_done;
    logic                  w_bit_end;

    assign w_bit_end = (r_cnt == CNT_LAST);

    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt + CW'(1);
        w_idx    = r_idx;
        w_shift  = r_shift;
        w_par_en = r_par_en;
        w_parity = r_parity;
        w_done   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt = '0;
                if (tx_valid) begin
                    w_state  = S_START;
                    w_idx    = '0;
                    w_shift  = tx_data;
                    w_par_en = parity_en;
                    w_parity = (^tx_data) ^ parity_odd;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state = S_DATA;
                    w_cnt   = '0;
                    w_idx   = '0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt = '0;
                    if (r_idx == DATA_LAST) begin
                        w_state = r_par_en ? S_PARITY : S_STOP;
                        w_idx   = '0;
                    end else begin
                        w_shift = r_shift >> 1;
                        w_idx   = r_idx + IW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state = S_STOP;
                    w_cnt   = '0;
                    w_idx   = '0;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_cnt = '0;
                    if (r_idx == STOP_LAST) begin
                        w_state = S_IDLE;
                        w_idx   = '0;
                        w_done  = 1'b1;
                    end else begin
                        w_idx = r_idx + IW'(1);
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
                w_cnt   = '0;
                w_idx   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they register
        // in step with it; the line idles at stop level.
        w_sel   = STOP_BIT_SELECT;
        w_sdata = 1'b1;
        case (w_state)
            S_START: begin
                w_sel   = START_BIT_SELECT;
                w_sdata = 1'b0;
            end
            S_DATA: begin
                w_sel   = SERIAL_DATA_BIT_SELECT;
                w_sdata = w_shift[0];
            end
            S_PARITY: begin
                w_sel = PARITY_BIT_SELECT;
            end
            default: begin
                w_sel   = STOP_BIT_SELECT;
                w_sdata = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_par_en <= 1'b0;
            r_parity <= 1'b0;
            r_sel    <= STOP_BIT_SELECT;
            r_sdata  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_idx    <= w_idx;
            r_shift  <= w_shift;
            r_par_en <= w_par_en;
            r_parity <= w_parity;
            r_sel    <= w_sel;
            r_sdata  <= w_sdata;
            r_busy   <= (w_state != S_IDLE);
            r_done   <= w_done;
            r_ready  <= (w_state == S_IDLE);
        end
    end

    assign tx_ready    = r_ready;
    assign bit_select  = r_sel;
    assign serial_data = r_sdata;
    assign parity_bit  = r_parity;
    assign tx_busy     = r_busy;
    assign tx_done     = r_done;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Testbench for uart_tx_ctrl: a per-cycle expected-output stream is
// queued as frames are requested and compared cycle by cycle.
module tb_uart_tx_ctrl;

    localparam int CPB = 4;
    localparam int DW  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          parity_en = 1'b0;
    logic          parity_odd = 1'b0;
    logic [1:0]    bit_select;
    logic          serial_data;
    logic          parity_bit;
    logic          tx_busy;
    logic          tx_done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] sel;
        logic       sd;
        logic       par;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t q[$];
    exp_t e;
    logic m_par = 1'b0;

    uart_tx_ctrl #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .bit_select (bit_select),
        .serial_data(serial_data),
        .parity_bit (parity_bit),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input exp_t x);
        logic [6:0] obs;
        logic [6:0] req;
        obs = {bit_select, serial_data, parity_bit,
               tx_busy, tx_done, tx_ready};
        req = {x.sel, x.sd, x.par, x.busy, x.done, ~x.busy};
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s t=%0t: observed %b expected %b",
                   tag, $time, obs, req);
        end
    endtask

    task automatic push(input logic [1:0] s, input logic d,
                        input logic p, input logic b,
                        input logic dn, input int n);
        exp_t x;
        x.sel  = s;
        x.sd   = d;
        x.par  = p;
        x.busy = b;
        x.done = dn;
        for (int k = 0; k < n; k++) q.push_back(x);
    endtask

    task automatic push_frame(input logic [DW-1:0] d,
                              input logic pe, input logic po);
        logic p;
        p = (^d) ^ po;
        push(2'b00, 1'b0, p, 1'b1, 1'b0, CPB);
        for (int i = 0; i < DW; i++)
            push(2'b10, d[i], p, 1'b1, 1'b0, CPB);
        if (pe) push(2'b11, 1'b1, p, 1'b1, 1'b0, CPB);
        push(2'b01, 1'b1, p, 1'b1, 1'b0, CPB);
        push(2'b01, 1'b1, p, 1'b0, 1'b1, 1);
    endtask

    // Monitor: one comparison per cycle, sampled 1 time unit after
    // the rising edge.
    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            m_par = 1'b0;
            e = '{sel: 2'b01, sd: 1'b1, par: 1'b0,
                  busy: 1'b0, done: 1'b0};
            chk("reset", e);
        end else if (q.size() > 0) begin
            e = q.pop_front();
            m_par = e.par;
            chk("frame", e);
        end else begin
            e = '{sel: 2'b01, sd: 1'b1, par: m_par,
                  busy: 1'b0, done: 1'b0};
            chk("idle", e);
        end
    end

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL drain: %0d entries left, expected 0", q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic send(input logic [DW-1:0] d,
                        input logic pe, input logic po);
        @(negedge clk);
        tx_data    = d;
        parity_en  = pe;
        parity_odd = po;
        tx_valid   = 1'b1;
        push_frame(d, pe, po);
        @(negedge clk);
        tx_valid   = 1'b0;
        tx_data    = DW'($urandom);
        parity_en  = 1'($urandom);
        parity_odd = 1'($urandom);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        send(8'h55, 1'b0, 1'b0);
        drain(200);

        send(8'hA3, 1'b1, 1'b0);
        drain(200);

        // Requests while busy are ignored and input changes
        // do not disturb the frame in flight.
        send(8'hA3, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        tx_data    = 8'hFF;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        tx_valid   = 1'b1;
        repeat (20) @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        drain(200);

        send(8'h07, 1'b1, 1'b0);
        drain(200);

        // Back-to-back with tx_valid held high.
        @(negedge clk);
        tx_data    = 8'h12;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        tx_valid   = 1'b1;
        push_frame(8'h12, 1'b0, 1'b0);
        @(negedge clk);
        tx_data    = 8'h34;
        parity_en  = 1'b1;
        parity_odd = 1'b1;
        push_frame(8'h34, 1'b1, 1'b1);
        repeat (41) @(negedge clk);
        tx_valid = 1'b0;
        drain(200);

        // Reset during data bit 3, then accept on the first cycle
        // after reset releases.
        @(negedge clk);
        tx_data    = 8'h5A;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        tx_valid   = 1'b1;
        push_frame(8'h5A, 1'b0, 1'b0);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        tx_data    = 8'hC3;
        parity_en  = 1'b1;
        parity_odd = 1'b0;
        tx_valid   = 1'b1;
        push_frame(8'hC3, 1'b1, 1'b0);
        @(negedge clk);
        tx_valid = 1'b0;
        drain(200);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
